// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter feeding a shared ALU, with registered operands
// and a 2-entry response FIFO per requester.
module alu_arbiter #(
  parameter int DATA_W = 12,
  parameter int OP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy
);
  logic stage_valid, stage_owner, last_grant;
  logic [1:0] push, pop, elig, grant, nonempty;
  logic [1:0][DATA_W-1:0] head;
  assign push = {stage_valid & stage_owner, stage_valid & ~stage_owner};
  assign pop = rsp_valid & rsp_ready;
  // A port may only be granted if its FIFO will still have room when the result lands.
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [1:0] count, count_nxt;
    logic wr, rd;
    logic [DATA_W-1:0] mem [2];
    assign count_nxt = count + 2'(push[i]) - 2'(pop[i]);
    assign elig[i] = req_valid[i] & (count_nxt <= 2'd1);
    assign rsp_valid[i] = count != 2'd0;
    assign nonempty[i] = rsp_valid[i];
    assign head[i] = mem[rd];
    always_ff @(posedge clk)
      if (rst) begin
        count <= 2'd0;
        wr <= 1'b0;
        rd <= 1'b0;
        mem[0] <= '0;
        mem[1] <= '0;
      end else begin
        count <= count_nxt;
        if (push[i]) begin
          mem[wr] <= alu_result;
          wr <= ~wr;
        end
        if (pop[i]) rd <= ~rd;
      end
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push[i] && !pop[i] && count == 2'd2));
  end
  assign grant = rst ? 2'b00 : (&elig) ? (last_grant ? 2'b01 : 2'b10) : elig;
  assign req_ready = grant;
  assign rsp0_data = head[0];
  assign rsp1_data = head[1];
  assign busy = stage_valid | (|nonempty);
  always_ff @(posedge clk)
    if (rst) begin
      stage_valid <= 1'b0;
      stage_owner <= 1'b0;
      last_grant <= 1'b1;
      alu_opcode <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
    end else begin
      stage_valid <= |grant;
      if (|grant) begin
        stage_owner <= grant[1];
        last_grant <= grant[1];
        alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
        alu_op1 <= grant[1] ? req1_op1 : req0_op1;
        alu_op2 <= grant[1] ? req1_op2 : req0_op2;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed scenarios checked against a queue-based model of
// outstanding results per port.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0] r_opc [2];
  logic [11:0] r_a [2];
  logic [11:0] r_b [2];
  logic [2:0] alu_opcode;
  logic [11:0] alu_op1, alu_op2, alu_result, rsp0_data, rsp1_data;
  logic busy;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] d;
    int t;
  } ent_t;
  ent_t q [2][$];
  int cyc = 0;
  int m_last = 1;
  logic [1:0] e_ready, e_rv, e_pop;
  logic [11:0] e_d [2];
  logic e_busy;
  logic [2:0] e_opc = 3'd0;
  logic [11:0] e_a = 12'd0;
  logic [11:0] e_b = 12'd0;

  alu_arbiter #(.DATA_W(12), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(r_opc[0]), .req1_opcode(r_opc[1]),
    .req0_op1(r_a[0]), .req0_op2(r_b[0]), .req1_op1(r_a[1]), .req1_op2(r_b[1]),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] alu_f(input logic [2:0] o, input logic [11:0] a, input logic [11:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[3:0];
      3'd6: return a >> b[3:0];
      default: return {11'd0, a < b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_op1, alu_op2);

  // Expected outputs for the current cycle, from the outstanding results per port.
  task automatic model_eval();
    logic [1:0] el;
    int w;
    for (int i = 0; i < 2; i++) begin
      e_rv[i] = q[i].size() > 0 && q[i][0].t <= cyc;
      e_d[i] = e_rv[i] ? q[i][0].d : 12'h000;
      e_pop[i] = e_rv[i] & rsp_ready[i];
      el[i] = req_valid[i] && (q[i].size() - int'(e_pop[i]) <= 1);
    end
    e_ready = 2'b00;
    if (!rst && el != 2'b00) begin
      w = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
      e_ready[w] = 1'b1;
    end
    e_busy = (q[0].size() + q[1].size()) > 0;
  endtask

  task automatic model_commit();
    ent_t e;
    if (rst) begin
      q[0].delete();
      q[1].delete();
      m_last = 1;
      e_opc = 3'd0;
      e_a = 12'd0;
      e_b = 12'd0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (e_pop[i]) void'(q[i].pop_front());
      for (int i = 0; i < 2; i++)
        if (e_ready[i]) begin
          e.d = alu_f(r_opc[i], r_a[i], r_b[i]);
          e.t = cyc + 2;
          q[i].push_back(e);
          m_last = i;
          e_opc = r_opc[i];
          e_a = r_a[i];
          e_b = r_b[i];
        end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic rand_port(input int i);
    r_opc[i] = 3'($urandom_range(0, 7));
    r_a[i] = 12'($urandom);
    r_b[i] = 12'($urandom);
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample();
    advance();
    sample();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%b exp 00/0", rsp_valid, busy); end
    checks++; if ({alu_opcode, alu_op1, alu_op2} !== 27'd0) begin errors++; $display("FAIL reset_alu got %h %h %h exp 0", alu_opcode, alu_op1, alu_op2); end
    checks++; if (rsp0_data !== 12'h000 || rsp1_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h %h exp 0", rsp0_data, rsp1_data); end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    r_opc[0] = 3'd0;
    r_a[0] = 12'h004;
    r_b[0] = 12'h001;
    sample();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    advance();
    req_valid = 2'b00;
    sample();
    checks++; if (alu_op1 !== 12'h004 || alu_op2 !== 12'h001 || alu_opcode !== 3'd0) begin errors++; $display("FAIL single_alu got %h %h %h exp 0 004 001", alu_opcode, alu_op1, alu_op2); end
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_mid got %b/%b exp 00/1", rsp_valid, busy); end
    advance();
    sample();
    checks++; if (rsp_valid !== 2'b01 || rsp0_data !== 12'h005) begin errors++; $display("FAIL single_rsp got %b %h exp 01 005", rsp_valid, rsp0_data); end
    rsp_ready = 2'b11;
    advance();
    sample();
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_done got %b/%b exp 00/0", rsp_valid, busy); end
    advance();
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      rand_port(0);
      rand_port(1);
      sample();
      checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10); end
      checks++; if (rsp_valid !== e_rv) begin errors++; $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, e_rv); end
      if (e_rv[0]) begin n0++; checks++; if (rsp0_data !== e_d[0]) begin errors++; $display("FAIL rr_data0 got %h exp %h", rsp0_data, e_d[0]); end end
      if (e_rv[1]) begin n1++; checks++; if (rsp1_data !== e_d[1]) begin errors++; $display("FAIL rr_data1 got %h exp %h", rsp1_data, e_d[1]); end end
      advance();
    end
    checks++; if (n0 != 7 || n1 != 7) begin errors++; $display("FAIL rr_rsp_count got %0d/%0d exp 7/7", n0, n1); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    drain();
    rsp_ready = 2'b01;
    rand_port(1);
    for (int k = 0; k < 10; k++) begin
      req_valid = {idx < 4, 1'b1};
      rand_port(0);
      sample();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL bp_grant k=%0d got %b exp %b", k, req_ready, e_ready); end
      checks++; if (rsp_valid !== e_rv) begin errors++; $display("FAIL bp_rsp_valid k=%0d got %b exp %b", k, rsp_valid, e_rv); end
      if (k >= 4) begin checks++; if (req_ready !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL bp_blocked k=%0d got %b/%b exp 01/1", k, req_ready, busy); end end
      if (req_ready[1]) begin idx++; rand_port(1); end
      advance();
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
    rsp_ready = 2'b11;
    for (int k = 0; k < 10 && idx < 4; k++) begin
      req_valid = {idx < 4, 1'b1};
      rand_port(0);
      sample();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL bp_drain_grant got %b exp %b", req_ready, e_ready); end
      if (e_rv[1]) begin checks++; if (rsp1_data !== e_d[1]) begin errors++; $display("FAIL bp_drain_data got %h exp %h", rsp1_data, e_d[1]); end end
      if (req_ready[1]) begin idx++; rand_port(1); end
      advance();
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_finish got %0d exp 4", idx); end
  endtask

  task automatic test_streaming();
    int n = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    drain();
    rsp_ready = 2'b01;
    for (int k = 0; k < 14; k++) begin
      req_valid = {1'b0, n < 8};
      r_opc[0] = 3'(n);
      r_a[0] = 12'h320;
      r_b[0] = 12'h3E0;
      sample();
      if (n < 8) begin checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stream_ready n=%0d got %b exp 01", n, req_ready); end end
      if (rsp_valid[0]) begin
        checks++; if (rsp0_data !== alu_f(3'(got), 12'h320, 12'h3E0)) begin errors++; $display("FAIL stream_data op=%0d got %h exp %h", got, rsp0_data, alu_f(3'(got), 12'h320, 12'h3E0)); end
        if (first < 0) first = k;
        last = k;
        got++;
      end
      if (req_ready[0]) n++;
      advance();
    end
    checks++; if (got != 8 || last - first != 7) begin errors++; $display("FAIL stream_count got %0d span %0d exp 8 span 7", got, last - first); end
  endtask

  task automatic test_full_pop();
    drain();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      rand_port(0);
      sample();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL full_fill k=%0d got %b exp %b", k, req_ready, e_ready); end
      advance();
    end
    rand_port(0);
    sample();
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin errors++; $display("FAIL full_block got %b/%b exp 00/01", req_ready, rsp_valid); end
    advance();
    rsp_ready = 2'b01;
    sample();
    checks++; if (req_ready !== 2'b01 || rsp0_data !== e_d[0]) begin errors++; $display("FAIL full_pop_push got %b %h exp 01 %h", req_ready, rsp0_data, e_d[0]); end
    advance();
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (rsp_valid !== 2'b01 || rsp0_data !== e_d[0] || req_ready !== e_ready) begin errors++; $display("FAIL full_next k=%0d got %b %h %b exp 01 %h %b", k, rsp_valid, rsp0_data, req_ready, e_d[0], e_ready); end
      advance();
    end
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (rsp_valid !== e_rv || (e_rv[0] && rsp0_data !== e_d[0])) begin errors++; $display("FAIL full_drain got %b %h exp %b %h", rsp_valid, rsp0_data, e_rv, e_d[0]); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drain();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      rand_port(0);
      rand_port(1);
      sample();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL mid_fill got %b exp %b", req_ready, e_ready); end
      advance();
    end
    rst = 1'b1;
    sample();
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b11 || busy !== 1'b1) begin errors++; $display("FAIL mid_in_reset got %b %b %b exp 00 11 1", req_ready, rsp_valid, busy); end
    advance();
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    sample();
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got %b/%b exp 00/0", rsp_valid, busy); end
    checks++; if ({alu_opcode, alu_op1, alu_op2, rsp0_data, rsp1_data} !== 51'd0) begin errors++; $display("FAIL mid_zero got %h %h %h %h %h exp 0", alu_opcode, alu_op1, alu_op2, rsp0_data, rsp1_data); end
    advance();
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_stale k=%0d got %b exp 00", k, rsp_valid); end
      advance();
    end
    req_valid = 2'b11;
    sample();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_tie got %b exp 01", req_ready); end
    advance();
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      rand_port(0);
      rand_port(1);
      sample();
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_grant k=%0d got %b exp %b", k, req_ready, e_ready); end
      checks++; if (rsp_valid !== e_rv || busy !== e_busy) begin errors++; $display("FAIL rnd_status k=%0d got %b/%b exp %b/%b", k, rsp_valid, busy, e_rv, e_busy); end
      checks++; if (alu_opcode !== e_opc || alu_op1 !== e_a || alu_op2 !== e_b) begin errors++; $display("FAIL rnd_alu k=%0d got %h %h %h exp %h %h %h", k, alu_opcode, alu_op1, alu_op2, e_opc, e_a, e_b); end
      if (e_rv[0]) begin checks++; if (rsp0_data !== e_d[0]) begin errors++; $display("FAIL rnd_data0 k=%0d got %h exp %h", k, rsp0_data, e_d[0]); end end
      if (e_rv[1]) begin checks++; if (rsp1_data !== e_d[1]) begin errors++; $display("FAIL rnd_data1 k=%0d got %h exp %h", k, rsp1_data, e_d[1]); end end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      r_opc[i] = 3'd0;
      r_a[i] = 12'd0;
      r_b[i] = 12'd0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_streaming();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 12-bit ALU. The execute stage and a secondary requester (address/branch-compare unit) both issue `{opcode, op_1, op_2}` through valid/ready handshakes. The block grants one request per cycle, round-robin, and registers the selected operands into the ALU inputs. It captures the combinational ALU result one cycle later and returns it through a per-requester 2-entry response FIFO.

## Interface
- `DATA_W`, 12, operand/result width
- `OP_W`, 3, opcode width
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous, active-high reset
- `req_valid[1:0]` in 2, request valid per port (port 0 = execute stage, port 1 = secondary)
- `req_ready[1:0]` out 2, request accepted this cycle (combinational grant)
- `req0_opcode`, `req1_opcode` in OP_W, opcode per port
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2` in DATA_W, operands per port
- `alu_opcode` out OP_W, registered ALU opcode
- `alu_op1`, `alu_op2` out DATA_W, registered ALU operands
- `alu_result` in DATA_W, combinational ALU output
- `rsp_valid[1:0]` out 2, response FIFO head valid per port
- `rsp_ready[1:0]` in 2, consumer pops head per port
- `rsp0_data`, `rsp1_data` out DATA_W, FIFO head data per port
- `busy` out 1, stage valid or any FIFO non-empty

## Operation
- **Stage register:** `stage_valid`, `stage_owner`, `alu_opcode/op1/op2`. It loads on a grant and clears (`stage_valid=0`) when there is no grant. The ALU operands hold their last value when no grant occurs.
- **Push into FIFO:** when `stage_valid`, `alu_result` is pushed into FIFO[`stage_owner`] at the next edge.
- **Pop from FIFO:** `pop_i = rsp_valid[i] & rsp_ready[i]`. The pop happens the same edge as any push, and count updates as `count + push - pop`.
- **Eligibility:** `elig_i = req_valid[i] & (count_i + push_i - pop_i <= 1)`. Here `count_i` is in {0,1,2} and `push_i = stage_valid & stage_owner==i`. This guarantees a slot for the result landing two edges later, even if the consumer never pops.
- **Grant, round-robin:**
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port ≠ `last_grant` is granted.
  - `last_grant` updates only on a grant. Its reset value is 1, so port 0 wins the first tie.
- `req_ready[i]` = grant to port i. At most one bit is high per cycle. It is 0 while `rst` is high.
- **Response order:** responses on each port come back in issue order. There is no cross-port ordering.
- **FIFO:** 2 entries per port, rd/wr pointers wrap modulo 2, and the count saturates at 2 by construction. An overflow is an assertion failure.
- **Full:** at `count_i==2` with no pop, port i is ineligible and `req_ready[i]` stays 0. The other port proceeds.
- **Empty:** `rsp_valid[i]=0` and `rsp_ready[i]` is ignored.

## Timing
- **Latency:** a request accepted at edge N is in the stage after N. The result is written at edge N+1, and `rsp_valid` is high from the cycle after N+1 (2-cycle accept-to-response).
- **Throughput:** 1 grant per cycle aggregate. A single port with `rsp_ready` held high sustains 1 op/cycle.
- **Simultaneous push and pop** on a full FIFO: legal, and the count stays at 2.
- **Reset values,** applied at the `rst` edge:
  - `stage_valid=0`
  - `alu_opcode=0`, `alu_op1=0`, `alu_op2=0`
  - FIFO counts and pointers 0, so `rsp_valid=0` and `rsp*_data=0`
  - `busy=0`, `last_grant=1`
- **Reset mid-operation:** in-flight and buffered results are discarded and no response is produced for them. `req_ready` is forced to 0 during reset cycles.

## Test plan
- **Single op:** port 0 issues opcode 0, op1=12'h004, op2=12'h001 at cycle 1.
  - `req_ready[0]=1` at cycle 1, and `alu_op1=004`/`alu_op2=001` in cycle 2.
  - `rsp_valid[0]=1` in cycle 3 with `rsp0_data` equal to the ALU model result.
- **Tie round-robin:** both ports valid continuously with `rsp_ready=2'b11`.
  - Grants alternate 0,1,0,1 starting with port 0, and each port sees 1 response every 2 cycles.
- **Backpressure:** port 1 issues 4 back-to-back requests with `rsp_ready[1]=0`.
  - Exactly 2 are accepted, then `req_ready[1]=0` while `count1==2` and `busy=1`.
  - Port 0 requests are still granted every cycle.
  - Raising `rsp_ready[1]` drains results 1 and 2 in order, and the 3rd request is then accepted.
- **Streaming:** port 0 issues 8 ops with opcodes 0–7, operands 12'h320 and 12'h3E0, with `rsp_ready[0]=1`.
  - 8 consecutive responses in opcode order, matching the model, with no bubbles after the first.
- **Full with simultaneous pop:** with `count0==2`, pop and push in the same cycle.
  - The count stays at 2 and the next head is the correct entry.
- **Reset mid-flight:** assert `rst` for 1 cycle while the stage is valid and both FIFOs hold entries.
  - The next cycle has `rsp_valid=00`, `busy=0`, and `alu_*=0`.
  - No stale response ever appears, and the first tie after reset grants port 0.
